// File: rtl/mos6502s_pkg.sv
// Shared types and constants for the 6502-side memory loader.
// Holds the loader state encoding and the bus widths used by the top level.
package mos6502s_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Writes at or above this address land in the ROM half of the map.
    localparam logic [ADDR_W-1:0] ROM_BASE = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/mos6502s_mem_loader.sv
// Streams a byte sequence into memory at a base address; zero added latency, one byte per cycle.
// Backpressure: in_ready follows the WRITE state; optional readback pass under MOS6502S_LOADER_VERIFY_EN.
module mos6502s_mem_loader
    import mos6502s_pkg::*;
#(
    parameter int ROM_GUARD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rw,
    output logic              mem_cs,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] count,
    output logic [DATA_W-1:0] checksum
);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_sum;
    logic              r_error;
    logic              w_guard;
    logic              w_write;

`ifdef MOS6502S_LOADER_VERIFY_EN
    localparam loader_state_t LAST_NEXT = ST_VERIFY;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_vidx;
    logic [DATA_W-1:0] r_vsum;
    logic [DATA_W-1:0] w_vsum_next;
    assign w_vsum_next = r_vsum + mem_rdata;
`else
    localparam loader_state_t LAST_NEXT = ST_DONE;
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;
`endif

    assign w_write  = (r_state == ST_WRITE);
    assign w_guard  = (ROM_GUARD != 0) && (r_cur_addr >= ROM_BASE);
    assign in_ready = w_write && !w_guard;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign error    = r_error;
    assign count    = r_count;
    assign checksum = r_sum;

    always_comb begin
        mem_cs    = 1'b0;
        mem_rw    = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_write) begin
            // A guarded ROM address drops chip select so nothing reaches memory.
            mem_cs    = in_valid && !w_guard;
            mem_rw    = 1'b0;
            mem_addr  = r_cur_addr;
            mem_wdata = in_data;
        end
`ifdef MOS6502S_LOADER_VERIFY_EN
        else if (r_state == ST_VERIFY) begin
            mem_cs   = 1'b1;
            mem_addr = r_base + r_vidx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_error     <= 1'b0;
`ifdef MOS6502S_LOADER_VERIFY_EN
            r_base      <= '0;
            r_vidx      <= '0;
            r_vsum      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= base_addr;
                        r_remaining <= length;
                        r_count     <= '0;
                        r_sum       <= '0;
                        r_error     <= 1'b0;
`ifdef MOS6502S_LOADER_VERIFY_EN
                        r_base      <= base_addr;
                        r_vidx      <= '0;
                        r_vsum      <= '0;
`endif
                        r_state     <= (length == '0) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_guard) begin
                        r_error <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (in_valid) begin
                        r_cur_addr  <= r_cur_addr + 16'd1;
                        r_count     <= r_count + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                        r_sum       <= r_sum + in_data;
                        if (r_remaining == 16'd1) begin
                            r_state <= LAST_NEXT;
                        end
                    end
                end
`ifdef MOS6502S_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    r_vsum <= w_vsum_next;
                    r_vidx <= r_vidx + 16'd1;
                    if (r_vidx == r_count - 16'd1) begin
                        if (w_vsum_next != r_sum) begin
                            r_error <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mos6502s_mem_loader.sv
// Scoreboard bench for mos6502s_mem_loader: a guarded and an unguarded instance share stimulus.
// Expected writes are queued as bytes are planned and compared against writes seen on the bus.
module tb_mos6502s_mem_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

`ifdef MOS6502S_LOADER_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [7:0]  mem_rdata;
    logic        sel;
    logic        corrupt_en;
    logic [15:0] corrupt_addr;

    logic        g_in_ready, g_mem_rw, g_mem_cs, g_busy, g_done, g_error;
    logic [15:0] g_mem_addr, g_count;
    logic [7:0]  g_mem_wdata, g_checksum;
    logic        n_in_ready, n_mem_rw, n_mem_cs, n_busy, n_done, n_error;
    logic [15:0] n_mem_addr, n_count;
    logic [7:0]  n_mem_wdata, n_checksum;

    logic        w_ready, w_rw, w_cs, w_busy, w_done, w_error;
    logic [15:0] w_addr, w_count;
    logic [7:0]  w_wdata, w_sum;

    logic [7:0]  mem [0:65535];
    logic [7:0]  stim [0:7];

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [15:0] rd_q[$];
    int          done_cnt = 0;
    int          bad_cs = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mos6502s_mem_loader #(.ROM_GUARD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(g_in_ready), .mem_addr(g_mem_addr),
        .mem_wdata(g_mem_wdata), .mem_rdata(mem_rdata), .mem_rw(g_mem_rw), .mem_cs(g_mem_cs),
        .busy(g_busy), .done(g_done), .error(g_error), .count(g_count), .checksum(g_checksum)
    );

    mos6502s_mem_loader #(.ROM_GUARD(0)) u_dut_ng (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(n_in_ready), .mem_addr(n_mem_addr),
        .mem_wdata(n_mem_wdata), .mem_rdata(mem_rdata), .mem_rw(n_mem_rw), .mem_cs(n_mem_cs),
        .busy(n_busy), .done(n_done), .error(n_error), .count(n_count), .checksum(n_checksum)
    );

    assign w_ready = sel ? n_in_ready  : g_in_ready;
    assign w_rw    = sel ? n_mem_rw    : g_mem_rw;
    assign w_cs    = sel ? n_mem_cs    : g_mem_cs;
    assign w_busy  = sel ? n_busy      : g_busy;
    assign w_done  = sel ? n_done      : g_done;
    assign w_error = sel ? n_error     : g_error;
    assign w_addr  = sel ? n_mem_addr  : g_mem_addr;
    assign w_count = sel ? n_count     : g_count;
    assign w_wdata = sel ? n_mem_wdata : g_mem_wdata;
    assign w_sum   = sel ? n_checksum  : g_checksum;

    // Combinational-read memory; the corruption hook flips one bit on readback only.
    assign mem_rdata = mem[w_addr] ^ ((corrupt_en && (w_addr == corrupt_addr)) ? 8'h01 : 8'h00);

    always @(posedge clk) begin
        if (w_cs && !w_rw) mem[w_addr] <= w_wdata;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (w_cs && !w_rw) obs_q.push_back(wr_t'{a: w_addr, d: w_wdata});
            if (w_cs && w_rw) rd_q.push_back(w_addr);
            if (w_done) done_cnt++;
            if (w_cs && (!w_busy || w_done)) bad_cs++;
            if (w_cs && !w_rw && !in_valid) bad_cs++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        base_addr = 16'h0000;
        length = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        rd_q.delete();
    endtask

    // Starts a load and feeds stim[] until done or the cycle budget runs out.
    task automatic drive(input logic [15:0] base, input logic [15:0] len, input int nb,
                         input bit toggle, output int cycles, output bit timed_out);
        int k = 0;
        int c = 0;
        bit got = 1'b0;
        bit ph = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = len;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got && c < 200) begin
            in_valid = (k < nb) && (!toggle || !ph);
            in_data  = stim[(k < 8) ? k : 7];
            @(negedge clk);
            if (w_done) got = 1'b1;
            if (in_valid && w_ready) k++;
            ph = !ph;
            c++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cycles = c;
        timed_out = !got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'hFF;
        base_addr = 16'h1234; length = 16'h0004; sel = 1'b0;
        #2;
        n_checks++;
        if ({g_in_ready, g_mem_cs, g_busy, g_done, g_error, g_count, g_checksum, g_mem_addr, g_mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_zero: got rdy=%b cs=%b busy=%b done=%b err=%b cnt=%h sum=%h addr=%h wd=%h, expected all 0",
                     g_in_ready, g_mem_cs, g_busy, g_done, g_error, g_count, g_checksum, g_mem_addr, g_mem_wdata);
        end
        n_checks++;
        if (g_mem_rw !== 1'b1) begin n_fail++; $display("FAIL reset_mem_rw: got %b expected 1", g_mem_rw); end
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({g_busy, g_mem_cs, g_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_held_over_clk: busy=%b cs=%b cnt=%h expected 0", g_busy, g_mem_cs, g_count);
        end
    endtask

    task automatic test_basic();
        int cyc; bit to; wr_t e; wr_t o; int d0;
        sel = 1'b0; apply_reset();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        for (int i = 0; i < 4; i++) exp_q.push_back(wr_t'{a: 16'h0200 + 16'(i), d: stim[i]});
        d0 = done_cnt;
        drive(16'h0200, 16'd4, 4, 1'b0, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
        n_checks++;
        if (cyc != 5 + 4 * VFY) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", cyc, 5 + 4 * VFY); end
        n_checks++;
        if ({w_count, w_sum, w_error} !== {16'd4, 8'hAA, 1'b0}) begin
            n_fail++; $display("FAIL basic_status: cnt=%h sum=%h err=%b expected 0004/aa/0", w_count, w_sum, w_error);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        int cyc; bit to; wr_t e; wr_t o; int d0; int b0;
        sel = 1'b0; apply_reset();
        stim[0] = 8'hA1; stim[1] = 8'hA2; stim[2] = 8'hA3; stim[3] = 8'hA4;
        for (int i = 0; i < 4; i++) exp_q.push_back(wr_t'{a: 16'h0300 + 16'(i), d: stim[i]});
        d0 = done_cnt; b0 = bad_cs;
        drive(16'h0300, 16'd4, 4, 1'b1, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bp_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
        n_checks++;
        if (bad_cs != b0) begin n_fail++; $display("FAIL bp_cs_only_when_valid: got %0d stray selects expected 0", bad_cs - b0); end
        n_checks++;
        if ({w_count, w_sum, w_error} !== {16'd4, 8'h8A, 1'b0}) begin
            n_fail++; $display("FAIL bp_status: cnt=%h sum=%h err=%b expected 0004/8a/0", w_count, w_sum, w_error);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_rom_guard();
        int cyc; bit to; wr_t e; wr_t o; int d0;
        sel = 1'b0; apply_reset();
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
        exp_q.push_back(wr_t'{a: 16'h7FFE, d: 8'h01});
        exp_q.push_back(wr_t'{a: 16'h7FFF, d: 8'h02});
        d0 = done_cnt;
        drive(16'h7FFE, 16'd4, 4, 1'b0, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL guard_timeout: no done within budget"); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL guard_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL guard_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
        n_checks++;
        if ({w_count, w_sum, w_error} !== {16'd2, 8'h03, 1'b1}) begin
            n_fail++; $display("FAIL guard_status: cnt=%h sum=%h err=%b expected 0002/03/1", w_count, w_sum, w_error);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL guard_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int cyc; bit to; wr_t e; wr_t o;
        sel = 1'b1; apply_reset();
        stim[0] = 8'h5A; stim[1] = 8'hA4;
        exp_q.push_back(wr_t'{a: 16'hFFFF, d: 8'h5A});
        exp_q.push_back(wr_t'{a: 16'h0000, d: 8'hA4});
        drive(16'hFFFF, 16'd2, 2, 1'b0, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL wrap_timeout: no done within budget"); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_write: got %h/%h expected %h/%h", o.a, o.d, e.a, e.d); end
        end
        n_checks++;
        if ({w_count, w_sum, w_error} !== {16'd2, 8'hFE, 1'b0}) begin
            n_fail++; $display("FAIL wrap_status: cnt=%h sum=%h err=%b expected 0002/fe/0", w_count, w_sum, w_error);
        end
        sel = 1'b0;
    endtask

    task automatic test_empty();
        int cyc; bit to; int d0; int b0;
        sel = 1'b0; apply_reset();
        d0 = done_cnt; b0 = bad_cs;
        drive(16'h0100, 16'd0, 0, 1'b0, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (cyc != 1 || to) begin n_fail++; $display("FAIL empty_latency: got %0d cycles expected 1", cyc); end
        n_checks++;
        if (obs_q.size() != 0 || rd_q.size() != 0 || bad_cs != b0) begin
            n_fail++; $display("FAIL empty_no_access: got %0d writes %0d reads expected 0", obs_q.size(), rd_q.size());
        end
        n_checks++;
        if ({w_count, w_sum, w_error} !== '0 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL empty_status: cnt=%h sum=%h err=%b done=%0d expected 0/0/0/1", w_count, w_sum, w_error, done_cnt - d0);
        end
    endtask

`ifdef MOS6502S_LOADER_VERIFY_EN
    task automatic test_verify();
        int cyc; bit to; logic [15:0] ra;
        for (int pass = 0; pass < 2; pass++) begin
            sel = 1'b0; apply_reset();
            corrupt_en = (pass == 1); corrupt_addr = 16'h0402;
            stim[0] = 8'hC0; stim[1] = 8'hC1; stim[2] = 8'hC2; stim[3] = 8'hC3;
            drive(16'h0400, 16'd4, 4, 1'b0, cyc, to);
            @(posedge clk); #1;
            n_checks++;
            if (cyc != 9 || to) begin n_fail++; $display("FAIL verify_latency: got %0d expected 9", cyc); end
            n_checks++;
            if (rd_q.size() != 4) begin n_fail++; $display("FAIL verify_nreads: got %0d expected 4", rd_q.size()); end
            for (int i = 0; i < 4 && rd_q.size() > 0; i++) begin
                ra = rd_q.pop_front(); n_checks++;
                if (ra !== 16'h0400 + 16'(i)) begin n_fail++; $display("FAIL verify_addr: got %h expected %h", ra, 16'h0400 + 16'(i)); end
            end
            n_checks++;
            if (w_error !== (pass == 1)) begin n_fail++; $display("FAIL verify_error: got %b expected %0d", w_error, pass); end
        end
        corrupt_en = 1'b0;
    endtask
`endif

    task automatic test_reset_midload();
        int cyc; bit to; int d0; wr_t o;
        sel = 1'b0; apply_reset();
        for (int i = 0; i < 8; i++) stim[i] = 8'h60 + 8'(i);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0600; length = 16'd8;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = stim[0];
        @(posedge clk); #1;
        in_data = stim[1];
        @(posedge clk); #1;
        in_data = stim[2];
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({g_mem_cs, g_busy, g_in_ready, g_done, g_count} !== '0 || g_mem_rw !== 1'b1) begin
            n_fail++; $display("FAIL midload_reset: cs=%b busy=%b rdy=%b done=%b cnt=%h rw=%b expected 0/0/0/0/0/1",
                               g_mem_cs, g_busy, g_in_ready, g_done, g_count, g_mem_rw);
        end
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        n_checks++;
        if (obs_q.size() != 2 || done_cnt != d0) begin
            n_fail++; $display("FAIL midload_abandon: got %0d writes %0d done expected 2 writes 0 done", obs_q.size(), done_cnt - d0);
        end
        o = (obs_q.size() > 1) ? obs_q[1] : wr_t'(0);
        n_checks++;
        if (o !== wr_t'{a: 16'h0601, d: 8'h61}) begin n_fail++; $display("FAIL midload_last_write: got %h/%h expected 0601/61", o.a, o.d); end
        obs_q.delete();
        stim[0] = 8'h77;
        d0 = done_cnt;
        drive(16'h0610, 16'd1, 1, 1'b0, cyc, to);
        @(posedge clk); #1;
        n_checks++;
        if (to || done_cnt - d0 != 1 || {w_count, w_sum, w_error} !== {16'd1, 8'h77, 1'b0}) begin
            n_fail++; $display("FAIL midload_restart: done=%0d cnt=%h sum=%h err=%b expected 1/0001/77/0", done_cnt - d0, w_count, w_sum, w_error);
        end
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== wr_t'{a: 16'h0610, d: 8'h77}) begin
            n_fail++; $display("FAIL midload_restart_write: got %0d writes expected one at 0610/77", obs_q.size());
        end
    endtask

    initial begin
        corrupt_en = 1'b0;
        corrupt_addr = 16'h0000;
        test_reset();
        test_basic();
        test_backpressure();
        test_rom_guard();
        test_wrap();
        test_empty();
`ifdef MOS6502S_LOADER_VERIFY_EN
        test_verify();
`endif
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
